// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package riscv_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W/8-1:0] BE_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle; slave is the arbiter's view.
interface mem_port_arbiter_if import riscv_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_valid;
  logic                  dm_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts data grants made while a fetch waits; saturates at MAX_RUN.
module arb_starve_ctr #(
  parameter int MAX_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);
  localparam logic [3:0] LIMIT = 4'(MAX_RUN);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (inc_i && cnt_q != LIMIT) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data; data has priority
// unless a waiting fetch has been passed over MAX_DM_RUN times.
module mem_port_arbiter import riscv_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_DM_RUN = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                if_valid_q, dm_valid_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

  logic idle, done, at_limit, fetch_prio, grant_if, grant_dm, ctr_clr, ctr_inc;

  // In the completion cycle the requester just served is excluded; its req is still high.
  assign idle       = (state_q == IDLE);
  assign done       = !idle && bus.mem_ready;
  assign fetch_prio = bus.if_req && at_limit;
  assign grant_dm   = bus.dm_req && ((idle && !fetch_prio) || (done && state_q == BUSY_IF));
  assign grant_if   = bus.if_req && ((idle && !(bus.dm_req && !fetch_prio)) ||
                                     (done && state_q == BUSY_DM));
  assign ctr_clr    = !bus.if_req || grant_if;
  assign ctr_inc    = grant_dm && bus.if_req;

  arb_starve_ctr #(.MAX_RUN(MAX_DM_RUN)) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (ctr_clr),
    .inc_i      (ctr_inc),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if (done) begin
        if (state_q == BUSY_IF) begin
          if_rdata_q <= bus.mem_rdata;
          if_valid_q <= 1'b1;
        end else begin
          dm_valid_q <= 1'b1;
          if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
        end
      end
      if (grant_dm) begin
        state_q     <= BUSY_DM;
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.dm_we;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
        mem_be_q    <= bus.dm_we ? bus.dm_be : '1;
      end else if (grant_if) begin
        state_q     <= BUSY_IF;
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_be_q    <= '1;
      end else if (done) begin
        state_q     <= IDLE;
        mem_req_q   <= 1'b0;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req && !if_valid_q;
  assign bus.dm_stall  = bus.dm_req && !dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .MAX_DM_RUN(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner, m_starve;
  logic        m_we, m_ifv, m_dmv;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
  logic [3:0]  m_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_we = 0; m_ifv = 0; m_dmv = 0;
    m_addr = 0; m_wdata = 0; m_ifr = 0; m_dmr = 0; m_be = 0;
  endtask

  task automatic model_step();
    bit done, can_if, can_dm;
    int win;
    if (rst) begin
      model_reset();
      return;
    end
    done   = (m_owner != 0) && bus.mem_ready;
    can_if = bus.if_req && (m_owner == 0 || (done && m_owner == 2));
    can_dm = bus.dm_req && (m_owner == 0 || (done && m_owner == 1));
    win = 0;
    if (can_if && can_dm) win = (m_starve == MAX) ? 1 : 2;
    else if (can_dm)      win = 2;
    else if (can_if)      win = 1;
    m_ifv = 0;
    m_dmv = 0;
    if (done) begin
      if (m_owner == 1) begin
        m_ifv = 1;
        m_ifr = bus.mem_rdata;
      end else begin
        m_dmv = 1;
        if (!m_we) m_dmr = bus.mem_rdata;
      end
    end
    if (!bus.if_req || win == 1) m_starve = 0;
    else if (win == 2 && m_starve < MAX) m_starve++;
    if (win == 1) begin
      m_we = 0; m_addr = bus.if_addr; m_be = BE_ALL_ONES;
    end else if (win == 2) begin
      m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
      m_be = bus.dm_we ? bus.dm_be : BE_ALL_ONES;
    end
    if (win != 0)  m_owner = win;
    else if (done) m_owner = 0;
  endtask

  task automatic compare();
    chk("mem_req", 32'(bus.mem_req), 32'(m_owner != 0));
    if (m_owner != 0) begin
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_be", 32'(bus.mem_be), 32'(m_be));
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("if_valid", 32'(bus.if_valid), 32'(m_ifv));
    chk("dm_valid", 32'(bus.dm_valid), 32'(m_dmv));
    chk("if_rdata", bus.if_rdata, m_ifr);
    chk("dm_rdata", bus.dm_rdata, m_dmr);
    chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !m_ifv));
    chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req && !m_dmv));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int wait_left;
    logic [31:0] exp_addr;

    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    model_reset();

    @(negedge clk);
    compare();
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    tick();
    rst = 0;
    tick();

    // single fetch with one memory wait cycle
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    chk("f_req_c1", 32'(bus.mem_req), 32'h1);
    chk("f_addr", bus.mem_addr, 32'h100);
    chk("f_we", 32'(bus.mem_we), 32'h0);
    chk("f_be", 32'(bus.mem_be), 32'hF);
    chk("f_stall_c1", 32'(bus.if_stall), 32'h1);
    tick();
    chk("f_req_c2", 32'(bus.mem_req), 32'h1);
    chk("f_valid_early", 32'(bus.if_valid), 32'h0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
    tick();
    chk("f_req_drop", 32'(bus.mem_req), 32'h0);
    chk("f_valid", 32'(bus.if_valid), 32'h1);
    chk("f_rdata", bus.if_rdata, 32'h00500093);
    chk("f_stall_end", 32'(bus.if_stall), 32'h0);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();
    chk("f_valid_once", 32'(bus.if_valid), 32'h0);

    // simultaneous fetch and load
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000;
    tick();
    chk("s_first_dm", bus.mem_addr, 32'h2000);
    bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
    tick();
    chk("s_b2b_req", 32'(bus.mem_req), 32'h1);
    chk("s_b2b_if", bus.mem_addr, 32'h104);
    chk("s_dm_valid", 32'(bus.dm_valid), 32'h1);
    chk("s_dm_rdata", bus.dm_rdata, 32'h11112222);
    bus.dm_req = 0; bus.mem_rdata = 32'h33334444;
    tick();
    chk("s_if_valid", 32'(bus.if_valid), 32'h1);
    chk("s_if_rdata", bus.if_rdata, 32'h33334444);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    // store leaves dm_rdata untouched
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h3000;
    bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
    tick();
    chk("st_we", 32'(bus.mem_we), 32'h1);
    chk("st_be", 32'(bus.mem_be), 32'h3);
    chk("st_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("st_valid", 32'(bus.dm_valid), 32'h1);
    chk("st_rdata_kept", bus.dm_rdata, 32'h11112222);
    bus.dm_req = 0; bus.dm_we = 0; bus.mem_ready = 0;
    tick();

    // both requesters held: data first, then strict back-to-back hand-off
    bus.if_req = 1; bus.if_addr = 32'h1000;
    bus.dm_req = 1; bus.dm_addr = 32'h5000;
    bus.mem_ready = 1;
    tick();
    chk("alt_0", bus.mem_addr, 32'h5000);
    for (int k = 1; k <= 5; k++) begin
      if (bus.dm_valid) bus.dm_addr = bus.dm_addr + 32'd4;
      if (bus.if_valid) bus.if_addr = bus.if_addr + 32'd4;
      bus.mem_rdata = $urandom;
      tick();
      exp_addr = (k % 2 == 1) ? 32'h1000 + 32'(4 * ((k - 1) / 2)) : 32'h5000 + 32'(4 * (k / 2));
      chk("alt_seq", bus.mem_addr, exp_addr);
    end
    bus.dm_req = 0;
    tick();
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    // reset while a load waits on memory
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h4000;
    tick();
    chk("r_busy", 32'(bus.mem_req), 32'h1);
    tick();
    bus.dm_req = 0;
    rst = 1;
    #1;
    chk("r_mem_req", 32'(bus.mem_req), 32'h0);
    chk("r_mem_addr", bus.mem_addr, 32'h0);
    chk("r_dm_rdata", bus.dm_rdata, 32'h0);
    chk("r_if_rdata", bus.if_rdata, 32'h0);
    model_reset();
    tick();
    rst = 0;
    tick();
    bus.if_req = 1; bus.if_addr = 32'h200;
    tick();
    chk("r_regrant", bus.mem_addr, 32'h200);
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE0001;
    tick();
    chk("r_if_rdata2", bus.if_rdata, 32'hCAFE0001);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    // stray mem_ready while idle
    bus.mem_ready = 1; bus.mem_rdata = 32'h77777777;
    tick();
    chk("idle_req", 32'(bus.mem_req), 32'h0);
    chk("idle_ifv", 32'(bus.if_valid), 32'h0);
    chk("idle_dmv", 32'(bus.dm_valid), 32'h0);
    bus.mem_ready = 0;
    tick();

    // random traffic
    wait_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!bus.if_req || bus.if_valid) begin
        bus.if_req = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end
      if (!bus.dm_req || bus.dm_valid) begin
        bus.dm_req = ($urandom_range(0, 2) != 0);
        bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_be = 4'($urandom_range(0, 15));
      end
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (wait_left == 0) begin
          bus.mem_ready = 1;
          wait_left = $urandom_range(0, 3);
        end else begin
          bus.mem_ready = 0;
          wait_left--;
        end
      end else begin
        bus.mem_ready = ($urandom_range(0, 7) == 0);
        wait_left = $urandom_range(0, 3);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
